// File: rtl/mole_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mole_pkg
// Description : Shared types and constants for the whack-a-mole round
//               controller: round FSM state encoding, LFSR seed and the
//               maximal-length LFSR tap table.
// Revision    : 1.0 - initial release
// ============================================================================
package mole_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GAP  = 2'd1,
    UP   = 2'd2
  } state_t;

  // Any non-zero seed works; all-zero would lock the LFSR.
  localparam logic [31:0] LFSR_SEED = 32'h0000_0001;

  // Feedback mask for a left-shifting Fibonacci LFSR: bit (t-1) set for
  // every polynomial tap t. All entries are maximal-length polynomials.
  function automatic logic [31:0] lfsr_taps(input int width);
    case (width)
      2:       lfsr_taps = 32'h0000_0003;
      3:       lfsr_taps = 32'h0000_0006;
      4:       lfsr_taps = 32'h0000_000C;
      5:       lfsr_taps = 32'h0000_0014;
      6:       lfsr_taps = 32'h0000_0030;
      7:       lfsr_taps = 32'h0000_0060;
      8:       lfsr_taps = 32'h0000_00B8;
      9:       lfsr_taps = 32'h0000_0110;
      10:      lfsr_taps = 32'h0000_0240;
      11:      lfsr_taps = 32'h0000_0500;
      12:      lfsr_taps = 32'h0000_0E08;
      13:      lfsr_taps = 32'h0000_1C80;
      14:      lfsr_taps = 32'h0000_3802;
      15:      lfsr_taps = 32'h0000_6000;
      16:      lfsr_taps = 32'h0000_D008;
      default: lfsr_taps = 32'h0000_00B8;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mole_lfsr.sv
`default_nettype none
// ============================================================================
// Module      : mole_lfsr
// Description : Fibonacci LFSR used to pick the next mole. Advances one step
//               only when 'step' is high; reset loads LFSR_SEED.
// Revision    : 1.0 - initial release
// Ports       : clock  in  1       system clock
//               resetn in  1       asynchronous active-low reset
//               step   in  1       advance the sequence by one state
//               lfsr   out LFSR_W  current LFSR state (never all-zero)
// ============================================================================
module mole_lfsr
  import mole_pkg::*;
#(
  parameter int LFSR_W = 8
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              step,
  output logic [LFSR_W-1:0] lfsr
);

  localparam logic [LFSR_W-1:0] c_taps = LFSR_W'(lfsr_taps(LFSR_W));
  localparam logic [LFSR_W-1:0] c_seed = LFSR_W'(LFSR_SEED);

  logic [LFSR_W-1:0] r_lfsr;
  logic              w_feedback;

  assign w_feedback = ^(r_lfsr & c_taps);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_lfsr <= c_seed;
    end else if (step) begin
      r_lfsr <= {r_lfsr[LFSR_W-2:0], w_feedback};
    end
  end

  assign lfsr = r_lfsr;

endmodule
`default_nettype wire

// File: rtl/mole_round_controller.sv
`default_nettype none
// ============================================================================
// Module      : mole_round_controller
// Description : Whack-a-mole round sequencer. Waits GAP_CYCLES, raises one
//               pseudo-random mole for 'speed' cycles, scores correct hits,
//               signals misses and keeps a saturating score.
//               Optional feature macro: MOLE_MISS_PENALTY_EN - a wrong button
//               while a mole is up costs one point and raises miss_pulse.
// Revision    : 1.0 - initial release
// Ports       : clock      in  1                 system clock
//               resetn     in  1                 asynchronous active-low reset
//               game       in  1                 1 = play, 0 = idle and clear
//               speed      in  CNT_W             mole up-time (0 acts as 1)
//               buttons    in  NUM_MOLES         raw active-high buttons
//               mole       out NUM_MOLES         one-hot raised mole, 0 if none
//               mole_idx   out clog2(NUM_MOLES)  current/last mole index
//               score      out SCORE_W           saturating score
//               hit_pulse  out 1                 one-cycle correct-hit pulse
//               miss_pulse out 1                 one-cycle timeout/penalty pulse
// ============================================================================
module mole_round_controller
  import mole_pkg::*;
#(
  parameter int NUM_MOLES  = 3,
  parameter int SCORE_W    = 8,
  parameter int CNT_W      = 28,
  parameter int GAP_CYCLES = 150_000_000,
  parameter int LFSR_W     = 8
) (
  input  logic                         clock,
  input  logic                         resetn,
  input  logic                         game,
  input  logic [CNT_W-1:0]             speed,
  input  logic [NUM_MOLES-1:0]         buttons,
  output logic [NUM_MOLES-1:0]         mole,
  output logic [$clog2(NUM_MOLES)-1:0] mole_idx,
  output logic [SCORE_W-1:0]           score,
  output logic                         hit_pulse,
  output logic                         miss_pulse
);

  localparam int                 c_idx_w     = $clog2(NUM_MOLES);
  localparam logic [CNT_W-1:0]   c_gap_load  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [SCORE_W-1:0] c_score_max = {SCORE_W{1'b1}};
  localparam logic [LFSR_W-1:0]  c_num_moles = LFSR_W'(NUM_MOLES);

  state_t               r_state;
  state_t               w_next_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [SCORE_W-1:0]   r_score;
  logic [c_idx_w-1:0]   r_idx;
  logic                 r_hit;
  logic                 r_miss;
  logic [NUM_MOLES-1:0] r_sync1;
  logic [NUM_MOLES-1:0] r_sync2;
  logic [NUM_MOLES-1:0] r_prev;
  logic [NUM_MOLES-1:0] w_edge;
  logic [NUM_MOLES-1:0] w_onehot;
  logic [LFSR_W-1:0]    w_lfsr;
  logic [c_idx_w-1:0]   w_new_idx;
  logic [CNT_W-1:0]     w_up_load;
  logic                 w_expire;
  logic                 w_step;
  logic                 w_hit;
  logic                 w_penalty;

  // Buttons: two synchroniser flops, then rising-edge detect on the
  // synchronised level so a held button produces exactly one edge.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
    end else begin
      r_sync1 <= buttons;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign w_edge    = r_sync2 & ~r_prev;
  assign w_onehot  = NUM_MOLES'(1) << r_idx;
  assign w_expire  = (r_cnt == '0);
  assign w_up_load = (speed == '0) ? '0 : speed - 1'b1;
  assign w_step    = game && (r_state == GAP) && w_expire;
  assign w_new_idx = c_idx_w'(w_lfsr % c_num_moles);
  // A correct edge always wins over expiry and over simultaneous wrong edges.
  assign w_hit     = (r_state == UP) && |(w_edge & w_onehot);

`ifdef MOLE_MISS_PENALTY_EN
  logic w_wrong;
  assign w_wrong   = |(w_edge & ~w_onehot);
  assign w_penalty = (r_state == UP) && !w_hit && w_wrong;
`else
  assign w_penalty = 1'b0;
`endif

  mole_lfsr #(
    .LFSR_W (LFSR_W)
  ) u_lfsr (
    .clock  (clock),
    .resetn (resetn),
    .step   (w_step),
    .lfsr   (w_lfsr)
  );

  // FSM state register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state logic; dropping 'game' aborts from any state
  always_comb begin
    w_next_state = r_state;
    if (!game) begin
      w_next_state = IDLE;
    end else begin
      case (r_state)
        IDLE:    w_next_state = GAP;
        GAP:     if (w_expire) w_next_state = UP;
        UP:      if (w_hit || w_expire) w_next_state = GAP;
        default: w_next_state = IDLE;
      endcase
    end
  end

  // FSM outputs
  always_comb begin
    mole = '0;
    if (r_state == UP) begin
      mole = w_onehot;
    end
  end

  // Round counter, mole index, score and pulses
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_cnt   <= '0;
      r_score <= '0;
      r_idx   <= '0;
      r_hit   <= 1'b0;
      r_miss  <= 1'b0;
    end else begin
      r_hit  <= 1'b0;
      r_miss <= 1'b0;
      if (!game) begin
        r_cnt   <= '0;
        r_score <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            r_cnt   <= c_gap_load;
            r_score <= '0;
          end
          GAP: begin
            if (w_expire) begin
              r_idx <= w_new_idx;
              r_cnt <= w_up_load;    // speed is only sampled here
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
          UP: begin
            if (w_hit) begin
              if (r_score != c_score_max) r_score <= r_score + 1'b1;
              r_hit <= 1'b1;
              r_cnt <= c_gap_load;
            end else begin
              if (w_penalty) begin
                if (r_score != '0) r_score <= r_score - 1'b1;
                r_miss <= 1'b1;
              end
              // Timer keeps running through penalised presses
              if (w_expire) begin
                r_miss <= 1'b1;
                r_cnt  <= c_gap_load;
              end else begin
                r_cnt <= r_cnt - 1'b1;
              end
            end
          end
          default: r_cnt <= '0;
        endcase
      end
    end
  end

  assign mole_idx   = r_idx;
  assign score      = r_score;
  assign hit_pulse  = r_hit;
  assign miss_pulse = r_miss;

endmodule
`default_nettype wire
